// File: rtl/ahb_mtx_in_stage.sv
// AHB matrix input stage: passes a transfer straight through when arbitration accepts it, and otherwise holds it until it is accepted.
// Define AHB_MTX_IN_STAGE_LOCK_EN to capture and forward HMASTLOCKS and keep locked sequences requesting.
module ahb_mtx_in_stage (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSELS,
    input  logic [31:0] HADDRS,
    input  logic [1:0]  HTRANSS,
    input  logic        HWRITES,
    input  logic [2:0]  HSIZES,
    input  logic [2:0]  HBURSTS,
    input  logic [3:0]  HPROTS,
    input  logic        HMASTLOCKS,
    input  logic        HREADYS,
    output logic        HREADYOUTS,
    output logic [1:0]  HRESPS,
    input  logic        sel_accept,
    input  logic        readyout_m,
    input  logic [1:0]  resp_m,
    output logic [31:0] HADDRM,
    output logic [1:0]  HTRANSM,
    output logic        HWRITEM,
    output logic [2:0]  HSIZEM,
    output logic [2:0]  HBURSTM,
    output logic [3:0]  HPROTM,
    output logic        HMASTLOCKM,
    output logic        trans_req,
    output logic        trans_pend
);

    logic        r_pend;
    logic        r_dataPh;
    logic [31:0] r_addr;
    logic [1:0]  r_trans;
    logic        r_write;
    logic [2:0]  r_size;
    logic [2:0]  r_burst;
    logic [3:0]  r_prot;
    logic        w_valid;
    logic        w_accept;

    // Gating with HRESETn keeps requests and HTRANSM quiet while reset is asserted.
    assign w_valid  = HSELS & HREADYS & HTRANSS[1] & ~r_pend & HRESETn;
    assign w_accept = (r_pend | w_valid) & sel_accept;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_pend   <= 1'b0;
            r_dataPh <= 1'b0;
            r_addr   <= '0;
            r_trans  <= '0;
            r_write  <= 1'b0;
            r_size   <= '0;
            r_burst  <= '0;
            r_prot   <= '0;
        end else begin
            if (r_pend) begin
                if (sel_accept)
                    r_pend <= 1'b0;
            end else if (w_valid && !sel_accept) begin
                r_pend  <= 1'b1;
                r_addr  <= HADDRS;
                r_trans <= HTRANSS;
                r_write <= HWRITES;
                r_size  <= HSIZES;
                r_burst <= HBURSTS;
                r_prot  <= HPROTS;
            end

            if (w_accept)
                r_dataPh <= 1'b1;
            else if (readyout_m)
                r_dataPh <= 1'b0;
        end
    end

`ifdef AHB_MTX_IN_STAGE_LOCK_EN
    logic r_lock;
    logic r_lockSeq;
    logic w_liveLock;

    assign w_liveLock = HSELS & HMASTLOCKS & HRESETn;

    // r_lockSeq keeps the request up between beats of a locked sequence until the master drops the lock.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_lock    <= 1'b0;
            r_lockSeq <= 1'b0;
        end else begin
            if (!r_pend && w_valid && !sel_accept)
                r_lock <= HMASTLOCKS;

            if (w_accept)
                r_lockSeq <= r_pend ? r_lock : HMASTLOCKS;
            else if (!r_pend && HREADYS && !w_liveLock)
                r_lockSeq <= 1'b0;
        end
    end

    assign HMASTLOCKM = r_pend ? r_lock : w_liveLock;
    assign trans_req  = r_pend | w_valid | w_liveLock | r_lockSeq;
`else
    logic w_unusedLock;

    assign w_unusedLock = HMASTLOCKS;
    assign HMASTLOCKM   = 1'b0;
    assign trans_req    = r_pend | w_valid;
`endif

    assign HADDRM  = r_pend ? r_addr  : HADDRS;
    assign HTRANSM = r_pend ? r_trans : (w_valid ? HTRANSS : 2'b00);
    assign HWRITEM = r_pend ? r_write : HWRITES;
    assign HSIZEM  = r_pend ? r_size  : HSIZES;
    assign HBURSTM = r_pend ? r_burst : HBURSTS;
    assign HPROTM  = r_pend ? r_prot  : HPROTS;

    assign trans_pend = r_pend;
    assign HREADYOUTS = r_pend ? 1'b0 : (r_dataPh ? readyout_m : 1'b1);
    assign HRESPS     = r_dataPh ? resp_m : 2'b00;

endmodule

// File: tb/tb_ahb_mtx_in_stage.sv
// Directed bench for ahb_mtx_in_stage; expectations are queued when stimulus is driven and compared once outputs settle.
// Lock checks follow AHB_MTX_IN_STAGE_LOCK_EN when it is defined for the build.
module tb_ahb_mtx_in_stage;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] BUSY   = 2'b01;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSELS;
    logic [31:0] HADDRS;
    logic [1:0]  HTRANSS;
    logic        HWRITES;
    logic [2:0]  HSIZES;
    logic [2:0]  HBURSTS;
    logic [3:0]  HPROTS;
    logic        HMASTLOCKS;
    logic        HREADYS;
    logic        HREADYOUTS;
    logic [1:0]  HRESPS;
    logic        sel_accept;
    logic        readyout_m;
    logic [1:0]  resp_m;
    logic [31:0] HADDRM;
    logic [1:0]  HTRANSM;
    logic        HWRITEM;
    logic [2:0]  HSIZEM;
    logic [2:0]  HBURSTM;
    logic [3:0]  HPROTM;
    logic        HMASTLOCKM;
    logic        trans_req;
    logic        trans_pend;

    typedef enum int {S_READY, S_RESP, S_TRANS, S_ADDR, S_WRITE, S_SIZE, S_REQ, S_PEND, S_LOCK} sig_t;

    typedef struct {
        string       tag;
        sig_t        sig;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   assertCount = 0;
    int   failCount   = 0;

    ahb_mtx_in_stage dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSELS(HSELS), .HADDRS(HADDRS),
        .HTRANSS(HTRANSS), .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS),
        .HPROTS(HPROTS), .HMASTLOCKS(HMASTLOCKS), .HREADYS(HREADYS),
        .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS), .sel_accept(sel_accept),
        .readyout_m(readyout_m), .resp_m(resp_m), .HADDRM(HADDRM), .HTRANSM(HTRANSM),
        .HWRITEM(HWRITEM), .HSIZEM(HSIZEM), .HBURSTM(HBURSTM), .HPROTM(HPROTM),
        .HMASTLOCKM(HMASTLOCKM), .trans_req(trans_req), .trans_pend(trans_pend)
    );

    always #5 HCLK = ~HCLK;

    function automatic logic [31:0] observe(sig_t s);
        case (s)
            S_READY: return {31'd0, HREADYOUTS};
            S_RESP:  return {30'd0, HRESPS};
            S_TRANS: return {30'd0, HTRANSM};
            S_ADDR:  return HADDRM;
            S_WRITE: return {31'd0, HWRITEM};
            S_SIZE:  return {29'd0, HSIZEM};
            S_REQ:   return {31'd0, trans_req};
            S_PEND:  return {31'd0, trans_pend};
            default: return {31'd0, HMASTLOCKM};
        endcase
    endfunction

    task automatic pushExp(input string tag, input sig_t s, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sig = s;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sig);
            assertCount++;
            assert (obs === e.exp) else begin
                failCount++;
                $error("[TB] FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic applyStimulus(input logic sel, input logic rdyS, input logic [31:0] addr,
                                 input logic [1:0] trans, input logic wr, input logic lock,
                                 input logic acc, input logic rdyM, input logic [1:0] rsp);
        HSELS      = sel;
        HREADYS    = rdyS;
        HADDRS     = addr;
        HTRANSS    = trans;
        HWRITES    = wr;
        HMASTLOCKS = lock;
        sel_accept = acc;
        readyout_m = rdyM;
        resp_m     = rsp;
    endtask

    task automatic nextCycle();
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        HSIZES  = 3'b010;
        HBURSTS = 3'b000;
        HPROTS  = 4'b0011;
        HRESETn = 1'b0;
        applyStimulus(1, 1, 32'h5555_0000, NONSEQ, 1, 0, 1, 1, 2'b00);

        // Reset values with a valid-looking transfer on the inputs
        nextCycle();
        nextCycle();
        pushExp("rst_ready", S_READY, 1);
        pushExp("rst_resp",  S_RESP,  0);
        pushExp("rst_trans", S_TRANS, 0);
        pushExp("rst_req",   S_REQ,   0);
        pushExp("rst_pend",  S_PEND,  0);
        checkOutput();
        HRESETn = 1'b1;
        applyStimulus(0, 1, 0, IDLE, 0, 0, 0, 1, 2'b00);

        // Zero-latency pass-through write
        nextCycle();
        applyStimulus(1, 1, 32'h2000_0040, NONSEQ, 1, 0, 1, 0, 2'b00);
        #1;
        pushExp("pt_trans", S_TRANS, 2);
        pushExp("pt_addr",  S_ADDR,  32'h2000_0040);
        pushExp("pt_write", S_WRITE, 1);
        pushExp("pt_req",   S_REQ,   1);
        pushExp("pt_pend",  S_PEND,  0);
        pushExp("pt_ready", S_READY, 1);
        checkOutput();
        nextCycle();
        applyStimulus(0, 0, 0, IDLE, 0, 0, 0, 0, 2'b00);
        #1;
        pushExp("pt_dph_wait", S_READY, 0);
        pushExp("pt_dph_pend", S_PEND,  0);
        pushExp("pt_dph_req",  S_REQ,   0);
        pushExp("pt_dph_idle", S_TRANS, 0);
        checkOutput();
        nextCycle();
        applyStimulus(0, 1, 0, IDLE, 0, 0, 0, 1, 2'b00);
        #1;
        pushExp("pt_dph_done", S_READY, 1);
        checkOutput();

        // Held read while arbitration refuses for three cycles
        nextCycle();
        applyStimulus(1, 1, 32'h0000_1000, NONSEQ, 0, 0, 0, 1, 2'b00);
        #1;
        pushExp("hold_req0",   S_REQ,   1);
        pushExp("hold_pend0",  S_PEND,  0);
        pushExp("hold_trans0", S_TRANS, 2);
        checkOutput();
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            applyStimulus(1, 0, 32'hDEAD_0000, SEQ, 1, 0, 0, 1, 2'b00);
            #1;
            pushExp("hold_pend",  S_PEND,  1);
            pushExp("hold_ready", S_READY, 0);
            pushExp("hold_addr",  S_ADDR,  32'h0000_1000);
            pushExp("hold_trans", S_TRANS, 2);
            pushExp("hold_write", S_WRITE, 0);
            pushExp("hold_size",  S_SIZE,  2);
            pushExp("hold_req",   S_REQ,   1);
            checkOutput();
        end
        nextCycle();
        applyStimulus(1, 0, 32'hDEAD_0000, SEQ, 1, 0, 1, 1, 2'b00);
        #1;
        pushExp("acc_pend",  S_PEND,  1);
        pushExp("acc_ready", S_READY, 0);
        pushExp("acc_addr",  S_ADDR,  32'h0000_1000);
        checkOutput();
        nextCycle();
        applyStimulus(0, 1, 0, IDLE, 0, 0, 0, 1, 2'b00);
        #1;
        pushExp("post_pend",  S_PEND,  0);
        pushExp("post_ready", S_READY, 1);
        pushExp("post_trans", S_TRANS, 0);
        pushExp("post_req",   S_REQ,   0);
        checkOutput();

        // Two-cycle ERROR response
        nextCycle();
        applyStimulus(1, 1, 32'h0000_3000, NONSEQ, 1, 0, 1, 1, 2'b00);
        #1;
        pushExp("err_addr_ready", S_READY, 1);
        pushExp("err_addr_resp",  S_RESP,  0);
        checkOutput();
        nextCycle();
        applyStimulus(0, 0, 0, IDLE, 0, 0, 0, 0, 2'b01);
        #1;
        pushExp("err1_resp",  S_RESP,  1);
        pushExp("err1_ready", S_READY, 0);
        checkOutput();
        nextCycle();
        applyStimulus(0, 1, 0, IDLE, 0, 0, 0, 1, 2'b01);
        #1;
        pushExp("err2_resp",  S_RESP,  1);
        pushExp("err2_ready", S_READY, 1);
        checkOutput();
        nextCycle();
        applyStimulus(0, 1, 0, IDLE, 0, 0, 0, 1, 2'b01);
        #1;
        pushExp("err_after_resp",  S_RESP,  0);
        pushExp("err_after_ready", S_READY, 1);
        checkOutput();

        // BUSY, deselected and wait-stated transfers are never captured
        nextCycle();
        applyStimulus(1, 1, 32'h0000_4000, BUSY, 0, 0, 0, 1, 2'b00);
        #1;
        pushExp("busy_req",   S_REQ,   0);
        pushExp("busy_trans", S_TRANS, 0);
        checkOutput();
        nextCycle();
        applyStimulus(0, 1, 32'h0000_4000, NONSEQ, 0, 0, 0, 1, 2'b00);
        #1;
        pushExp("nosel_req",  S_REQ,  0);
        pushExp("busy_pend",  S_PEND, 0);
        checkOutput();
        nextCycle();
        applyStimulus(1, 0, 32'h0000_4000, NONSEQ, 0, 0, 0, 1, 2'b00);
        #1;
        pushExp("nordy_req",  S_REQ,  0);
        pushExp("nosel_pend", S_PEND, 0);
        checkOutput();
        nextCycle();
        applyStimulus(0, 1, 0, IDLE, 0, 0, 0, 1, 2'b00);
        #1;
        pushExp("nordy_pend", S_PEND, 0);
        checkOutput();

        // Reset while a transfer is held
        nextCycle();
        applyStimulus(1, 1, 32'h0000_5000, NONSEQ, 0, 0, 0, 1, 2'b00);
        #1;
        pushExp("rp_req", S_REQ, 1);
        checkOutput();
        nextCycle();
        applyStimulus(1, 0, 32'h0000_5000, NONSEQ, 0, 0, 0, 1, 2'b00);
        #1;
        pushExp("rp_pend",  S_PEND,  1);
        pushExp("rp_ready", S_READY, 0);
        checkOutput();
        #1;
        HRESETn = 1'b0;
        applyStimulus(1, 1, 32'h0000_5000, NONSEQ, 0, 0, 1, 1, 2'b01);
        #1;
        pushExp("rp_rst_pend",  S_PEND,  0);
        pushExp("rp_rst_ready", S_READY, 1);
        pushExp("rp_rst_resp",  S_RESP,  0);
        pushExp("rp_rst_req",   S_REQ,   0);
        pushExp("rp_rst_trans", S_TRANS, 0);
        checkOutput();
        nextCycle();
        HRESETn = 1'b1;
        applyStimulus(0, 1, 0, IDLE, 0, 0, 0, 0, 2'b01);
        #1;
        pushExp("rp_rel_ready", S_READY, 1);
        pushExp("rp_rel_resp",  S_RESP,  0);
        pushExp("rp_rel_pend",  S_PEND,  0);
        pushExp("rp_rel_req",   S_REQ,   0);
        checkOutput();
        nextCycle();
        #1;
        pushExp("rp_rel2_ready", S_READY, 1);
        pushExp("rp_rel2_resp",  S_RESP,  0);
        checkOutput();

`ifdef AHB_MTX_IN_STAGE_LOCK_EN
        // Locked INCR4 with arbitration alternately refusing and accepting
        HBURSTS = 3'b011;
        for (int b = 0; b < 4; b++) begin
            nextCycle();
            applyStimulus(1, 1, 32'h0000_6000 + 32'(4 * b), (b == 0) ? NONSEQ : SEQ, 0, 1, 0, 1, 2'b00);
            #1;
            pushExp("lock_req_a",  S_REQ,  1);
            pushExp("lock_lock_a", S_LOCK, 1);
            checkOutput();
            nextCycle();
            applyStimulus(1, 0, 32'h0000_6000 + 32'(4 * b), (b == 0) ? NONSEQ : SEQ, 0, 1, 1, 1, 2'b00);
            #1;
            pushExp("lock_req_b",  S_REQ,  1);
            pushExp("lock_pend_b", S_PEND, 1);
            pushExp("lock_lock_b", S_LOCK, 1);
            checkOutput();
        end
        nextCycle();
        applyStimulus(0, 1, 0, IDLE, 0, 0, 0, 1, 2'b00);
        nextCycle();
        #1;
        pushExp("lock_release_req", S_REQ, 0);
        checkOutput();
`else
        // Lock input is ignored in the default build
        nextCycle();
        applyStimulus(1, 1, 32'h0000_6000, NONSEQ, 0, 1, 1, 1, 2'b00);
        #1;
        pushExp("nolock_lockm", S_LOCK, 0);
        pushExp("nolock_req",   S_REQ,  1);
        checkOutput();
        nextCycle();
        applyStimulus(0, 1, 0, IDLE, 0, 1, 0, 1, 2'b00);
        #1;
        pushExp("nolock_idle_lockm", S_LOCK, 0);
        pushExp("nolock_idle_req",   S_REQ,  0);
        checkOutput();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/ahb_mtx_in_stage.md
AHB_MTX_IN_STAGE -- requirements
Module: ahb_mtx_in_stage

Interface
REQ-001 HCLK  input  1  AHB system clock; all state on rising edge.
REQ-002 HRESETn  input  1  asynchronous active-low reset.
REQ-003 HSELS  input  1  slave select from upstream master.
REQ-004 HADDRS  input  32  transfer address.
REQ-005 HTRANSS  input  2  transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
REQ-006 HWRITES, HSIZES, HBURSTS, HPROTS  input  1/3/3/4  transfer attributes.
REQ-007 HMASTLOCKS  input  1  locked-transfer indicator.
REQ-008 HREADYS  input  1  bus-level HREADY seen by master.
REQ-009 HREADYOUTS  output  1  ready returned to master.
REQ-010 HRESPS  output  2  response returned to master (00 OKAY, 01 ERROR).
REQ-011 sel_accept  input  1  output arbitration has granted this port and target HREADYM=1 this cycle.
REQ-012 readyout_m  input  1  data-phase ready from selected output stage.
REQ-013 resp_m  input  2  data-phase response from selected output stage.
REQ-014 HADDRM, HTRANSM, HWRITEM, HSIZEM, HBURSTM, HPROTM, HMASTLOCKM  output  32/2/1/3/3/4/1  transfer presented to decoder/arbiters.
REQ-015 trans_req  output  1  request to output arbitration (feeds req_portN).
REQ-016 trans_pend  output  1  hold register occupied.

Function
REQ-017 Valid sample = HSELS & HREADYS & HTRANSS[1]; IDLE/BUSY never captured.
REQ-018 Valid sample with sel_accept=1 same cycle: pass-through, zero latency, no hold.
REQ-019 Valid sample with sel_accept=0: capture all attributes into hold register at clock edge; trans_pend=1 next cycle.
REQ-020 trans_pend=1: M-side outputs driven from hold register; otherwise from live S-side inputs.
REQ-021 trans_req = trans_pend | valid sample (combinational).
REQ-022 trans_pend clears on edge where sel_accept=1; sets data_ph.
REQ-023 data_ph register: set on edge when transfer accepted (live or held); cleared when readyout_m=1 and no new accept.
REQ-024 HREADYOUTS = 0 while trans_pend; else readyout_m while data_ph; else 1.
REQ-025 HRESPS = resp_m while data_ph; else OKAY; two-cycle ERROR from output stage passed unchanged.
REQ-026 trans_pend=1: new S-side samples ignored (HREADYOUTS low guarantees master holds).
REQ-027 Held transfer with HTRANS=SEQ presented as captured; no retyping.
REQ-028 trans_pend=0 and no valid sample: HTRANSM=00, trans_req=0.

Reset
REQ-029 HRESETn low: trans_pend=0, data_ph=0, hold register zero, HREADYOUTS=1, HRESPS=00, trans_req=0, HTRANSM=00.
REQ-030 Reset mid-pend or mid-data-phase discards transfer; no response generated after release.

Configuration
REQ-031 AHB_MTX_IN_STAGE_LOCK_EN defined: HMASTLOCKS captured/forwarded; trans_req held high while held/live lock asserted, sequence never split.
REQ-032 AHB_MTX_IN_STAGE_LOCK_EN undefined: HMASTLOCKM tied 0, no lock register, HMASTLOCKS ignored.

Verification
REQ-033 NONSEQ write 0x2000_0040, sel_accept=1 -> HTRANSM=10 same cycle, trans_pend stays 0, HREADYOUTS follows readyout_m next cycle.
REQ-034 NONSEQ read 0x0000_1000, sel_accept=0 for 3 cycles -> trans_pend=1, HREADYOUTS=0 three cycles, HADDRM=0x0000_1000 stable, clears on accept.
REQ-035 resp_m=01 two cycles in data phase -> HRESPS=01 both cycles, HREADYOUTS 0 then 1.
REQ-036 HTRANSS=01 (BUSY) or HSELS=0 with NONSEQ -> no capture, trans_req=0.
REQ-037 HRESETn low while trans_pend=1 -> all outputs at REQ-029 values immediately, no data phase after release.
REQ-038 LOCK_EN defined, locked INCR4 with sel_accept toggling -> trans_req continuous high through all 4 beats; undefined -> HMASTLOCKM=0.
